vga_stream_checker: RTL and testbench
=====================================

Name: vga_stream_checker

Overview:
- Synthesizable, parametrised self-checker for the VGA output path.
- Compares the displayed pixel stream (pixel position plus N-channel colour) against an expected-pixel stream supplied through a valid/ready handshake, restricted to a configurable view window.
- Counts per-channel mismatches and latches the first failing coordinate.
- Halts at a mismatch threshold; reports per-frame completion over a configurable number of frames.
- Sits beside the VGA controller; usable on-board (expected data fed from SRAM or UART) or in simulation.

Parameters:
CHANNELS, 3, number of colour channels per pixel
CH_WIDTH, 8, bits per channel
VIEW_LEFT, 160, first checked column (inclusive)
VIEW_RIGHT, 480, last checked column (exclusive)
VIEW_TOP, 120, first checked row (inclusive)
VIEW_BOTTOM, 360, last checked row (exclusive)
MAX_MISMATCHES, 10, threshold for Halt (strictly greater than)
NUM_FRAMES, 1, frames to check before Done
CNT_W, 16, mismatch counter width

Ports:
Clock  in  1  system clock (50 MHz)
Reset  in  1  synchronous, active-high reset
Start  in  1  one-cycle arm pulse
VGA_vsync  in  1  vertical sync, active low
Pixel_valid  in  1  pixel qualifier (one every other clock at 640x480)
Pixel_X  in  10  column of the current pixel
Pixel_Y  in  10  row of the current pixel
Pixel_data  in  CHANNELS*CH_WIDTH  displayed colour, channel 0 in the MSBs
Exp_valid  in  1  expected pixel available
Exp_data  in  CHANNELS*CH_WIDTH  expected colour, same packing as Pixel_data
Exp_ready  out  1  expected pixel consumed this cycle
Mismatch_count  out  CNT_W  saturating count of channel mismatches
Chan_err_mask  out  CHANNELS  sticky per-channel error flags
First_err_X  out  10  column of the first mismatch
First_err_Y  out  10  row of the first mismatch
Exp_underflow  out  1  sticky: in-window pixel arrived with Exp_valid low
Frame_count  out  8  completed frames
Busy  out  1  state is S_WAIT_FRAME or S_CHECK
Done  out  1  NUM_FRAMES frames completed
Halt  out  1  Mismatch_count > MAX_MISMATCHES
Frame_crc  out  16  per-frame signature (see Optional Feature)

Behaviour:
- Reset: all outputs 0; state S_IDLE.
- S_IDLE:
  - On Start: clear the counters, masks, sticky flags and Frame_count; go to S_WAIT_FRAME.
  - Start is ignored in all other states.
- S_WAIT_FRAME: wait for a VGA_vsync low-to-high edge (edge detected against a 1-cycle registered copy); then go to S_CHECK.
- S_CHECK:
  - A pixel is in-window when VIEW_LEFT <= X < VIEW_RIGHT and VIEW_TOP <= Y < VIEW_BOTTOM.
  - In-window, Pixel_valid and Exp_valid all high: Exp_ready = 1 combinationally in that cycle. Compare each channel.
  - Each unequal channel adds 1 to Mismatch_count in the next cycle (1-cycle latency); up to CHANNELS may be added per pixel. The count saturates at all-ones.
  - Chan_err_mask bits are set in the same cycle as the count update.
  - First_err_X/Y latch only while Mismatch_count == 0.
  - In-window pixel with Exp_valid low: set Exp_underflow; Exp_ready = 0; no compare; no count change.
  - Out-of-window pixels and Pixel_valid low: Exp_ready = 0; no action.
- Frame end: a VGA_vsync high-to-low edge in S_CHECK increments Frame_count.
  - If Frame_count reaches NUM_FRAMES: go to S_DONE.
  - Otherwise: go to S_WAIT_FRAME.
- Halt:
  - Asserts in the cycle Mismatch_count first exceeds MAX_MISMATCHES; go to S_HALT.
  - A compare pending in that cycle is still counted.
  - S_HALT wins over a simultaneous frame end.
- S_DONE / S_HALT: Done or Halt held high; outputs frozen; Start returns to the S_IDLE clear path.
- Reset mid-frame: immediate return to S_IDLE with outputs cleared; no partial-frame state is retained.
- Width rule: channel compare is unsigned equality on CH_WIDTH-bit slices; the counter add is zero-extended to CNT_W before saturation.

Optional Feature:
VGA_CHK_CRC_EN
- Defined:
  - Frame_crc is a CRC-16-CCITT (poly 0x1021, init 0xFFFF) over Pixel_data of every in-window pixel, MSB first, full word per pixel.
  - Updated in the cycle after each in-window Pixel_valid.
  - Reinitialised on S_WAIT_FRAME exit; holds its value after frame end until the next frame starts.
- Not defined: Frame_crc tied to 0; no CRC logic synthesised.

Decomposition:
- Package vga_chk_pkg holds:
  - state enum (S_IDLE, S_WAIT_FRAME, S_CHECK, S_DONE, S_HALT);
  - default view-window constants (640x480 display, 320x240 centred);
  - CRC polynomial and init constants.
- One sub-module, vga_chk_crc16: combinational next-CRC over a CHANNELS*CH_WIDTH word plus the state register; instantiated only under VGA_CHK_CRC_EN.

Test Plan:
- Start, one frame, every Exp_data = Pixel_data -> Mismatch_count 0, Done = 1 after the vsync fall, Frame_count 1, Chan_err_mask 000.
- Pixel (200,130) with green expected 0x40, got 0x41 -> Mismatch_count 1 one cycle later, mask 010, First_err = (200,130); later errors leave First_err unchanged.
- 4 pixels each wrong in all 3 channels -> count reaches 12 on the 4th; Halt at that cycle; state S_HALT; Done stays 0.
- Exp_valid low at in-window pixel (160,120) -> Exp_underflow = 1, Exp_ready = 0, count unchanged; out-of-window pixel (100,50) -> Exp_ready = 0.
- NUM_FRAMES = 2, Reset asserted mid second frame -> all outputs 0 next cycle; new Start then checks 2 full frames, Frame_count = 2.
- VGA_CHK_CRC_EN defined, single in-window pixel 0x000000 -> Frame_crc equals the reference CRC-16-CCITT of 24 zero bits from init 0xFFFF.

Source files
------------

// File: rtl/vga_chk_pkg.sv
// Shared types and constants for the VGA stream checker: FSM states, the
// default 320x240 view window centred in 640x480, and CRC-16-CCITT constants.
package vga_chk_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_FRAME = 3'd1,
        S_CHECK      = 3'd2,
        S_DONE       = 3'd3,
        S_HALT       = 3'd4
    } chk_state_e;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int VIEW_W   = 320;
    localparam int VIEW_H   = 240;

    localparam int DEF_VIEW_LEFT   = (H_ACTIVE - VIEW_W) / 2;
    localparam int DEF_VIEW_RIGHT  = DEF_VIEW_LEFT + VIEW_W;
    localparam int DEF_VIEW_TOP    = (V_ACTIVE - VIEW_H) / 2;
    localparam int DEF_VIEW_BOTTOM = DEF_VIEW_TOP + VIEW_H;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // One bit of an MSB-first CRC-16-CCITT shift.
    function automatic logic [15:0] crc16_bit(input logic [15:0] crc, input logic din);
        logic [15:0] shifted;
        shifted = {crc[14:0], 1'b0};
        if (crc[15] ^ din) begin
            crc16_bit = shifted ^ CRC_POLY;
        end else begin
            crc16_bit = shifted;
        end
    endfunction

endpackage

// File: rtl/vga_chk_crc16.sv
// Frame signature register: CRC-16-CCITT over whole pixel words, MSB first.
// Only instantiated when VGA_CHK_CRC_EN is defined.
module vga_chk_crc16
    import vga_chk_pkg::*;
#(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         init,
    input  logic         en,
    input  logic [W-1:0] data,
    output logic [15:0]  crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;
    logic [15:0] crc_next_s;

    // Fold the full pixel word into the running CRC, first bit = data MSB.
    always_comb begin
        crc_next_s = crc_q;
        for (int i = W - 1; i >= 0; i--) begin
            crc_next_s = crc16_bit(crc_next_s, data[i]);
        end
    end

    // Clear on arm, seed at frame start, advance per in-window pixel.
    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = 16'h0000;
        end else if (init) begin
            crc_d = CRC_INIT;
        end else if (en) begin
            crc_d = crc_next_s;
        end else begin
            crc_d = crc_q;
        end
    end

    // Signature register.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= 16'h0000;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/vga_stream_checker.sv
// Compares displayed VGA pixels against an expected stream inside a view window,
// counting channel mismatches. Optional frame CRC enabled by VGA_CHK_CRC_EN.
module vga_stream_checker
    import vga_chk_pkg::*;
#(
    parameter int CHANNELS       = 3,
    parameter int CH_WIDTH       = 8,
    parameter int VIEW_LEFT      = DEF_VIEW_LEFT,
    parameter int VIEW_RIGHT     = DEF_VIEW_RIGHT,
    parameter int VIEW_TOP       = DEF_VIEW_TOP,
    parameter int VIEW_BOTTOM    = DEF_VIEW_BOTTOM,
    parameter int MAX_MISMATCHES = 10,
    parameter int NUM_FRAMES     = 1,
    parameter int CNT_W          = 16
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         Start,
    input  logic                         VGA_vsync,
    input  logic                         Pixel_valid,
    input  logic [9:0]                   Pixel_X,
    input  logic [9:0]                   Pixel_Y,
    input  logic [CHANNELS*CH_WIDTH-1:0] Pixel_data,
    input  logic                         Exp_valid,
    input  logic [CHANNELS*CH_WIDTH-1:0] Exp_data,
    output logic                         Exp_ready,
    output logic [CNT_W-1:0]             Mismatch_count,
    output logic [CHANNELS-1:0]          Chan_err_mask,
    output logic [9:0]                   First_err_X,
    output logic [9:0]                   First_err_Y,
    output logic                         Exp_underflow,
    output logic [7:0]                   Frame_count,
    output logic                         Busy,
    output logic                         Done,
    output logic                         Halt,
    output logic [15:0]                  Frame_crc
);

    localparam int PIX_W = CHANNELS * CH_WIDTH;

    localparam logic [9:0]       WIN_L   = 10'(VIEW_LEFT);
    localparam logic [9:0]       WIN_R   = 10'(VIEW_RIGHT);
    localparam logic [9:0]       WIN_T   = 10'(VIEW_TOP);
    localparam logic [9:0]       WIN_B   = 10'(VIEW_BOTTOM);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_MISMATCHES);
    localparam logic [7:0]       NF_CNT  = 8'(NUM_FRAMES);

    chk_state_e          state_q, state_d;
    logic                vsync_q, vsync_d;
    logic [CNT_W-1:0]    mis_cnt_q, mis_cnt_d;
    logic [CHANNELS-1:0] mask_q, mask_d;
    logic [9:0]          fx_q, fx_d;
    logic [9:0]          fy_q, fy_d;
    logic                underflow_q, underflow_d;
    logic [7:0]          frame_cnt_q, frame_cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                halt_q, halt_d;

    logic                in_win_s;
    logic                check_s;
    logic                compare_s;
    logic                vsync_rise_s;
    logic                vsync_fall_s;
    logic [CHANNELS-1:0] neq_s;
    logic [CNT_W:0]      sum_s;
    logic [CNT_W-1:0]    sat_cnt_s;

    assign in_win_s     = (Pixel_X >= WIN_L) && (Pixel_X < WIN_R) &&
                          (Pixel_Y >= WIN_T) && (Pixel_Y < WIN_B);
    assign check_s      = (state_q == S_CHECK) && Pixel_valid && in_win_s;
    assign compare_s    = check_s && Exp_valid;
    assign vsync_rise_s = VGA_vsync && !vsync_q;
    assign vsync_fall_s = !VGA_vsync && vsync_q;
    assign Exp_ready    = compare_s;

    // Per-channel unsigned compare; channel 0 occupies the MSBs.
    always_comb begin
        neq_s = {CHANNELS{1'b0}};
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (Pixel_data[(CHANNELS-1-ch)*CH_WIDTH +: CH_WIDTH] !=
                Exp_data[(CHANNELS-1-ch)*CH_WIDTH +: CH_WIDTH]) begin
                neq_s[ch] = compare_s;
            end else begin
                neq_s[ch] = 1'b0;
            end
        end
    end

    // Add the number of failing channels with one guard bit, then saturate.
    always_comb begin
        sum_s = {1'b0, mis_cnt_q};
        for (int ch = 0; ch < CHANNELS; ch++) begin
            sum_s = sum_s + {{CNT_W{1'b0}}, neq_s[ch]};
        end
        if (sum_s[CNT_W]) begin
            sat_cnt_s = {CNT_W{1'b1}};
        end else begin
            sat_cnt_s = sum_s[CNT_W-1:0];
        end
    end

    // Checker FSM next-state and result-register updates.
    always_comb begin
        state_d     = state_q;
        vsync_d     = VGA_vsync;
        mis_cnt_d   = mis_cnt_q;
        mask_d      = mask_q;
        fx_d        = fx_q;
        fy_d        = fy_q;
        underflow_d = underflow_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            S_IDLE, S_DONE, S_HALT: begin
                if (Start) begin
                    mis_cnt_d   = {CNT_W{1'b0}};
                    mask_d      = {CHANNELS{1'b0}};
                    fx_d        = 10'd0;
                    fy_d        = 10'd0;
                    underflow_d = 1'b0;
                    frame_cnt_d = 8'd0;
                    state_d     = S_WAIT_FRAME;
                end else begin
                    state_d = state_q;
                end
            end
            S_WAIT_FRAME: begin
                if (vsync_rise_s) begin
                    state_d = S_CHECK;
                end else begin
                    state_d = S_WAIT_FRAME;
                end
            end
            S_CHECK: begin
                if (compare_s) begin
                    mis_cnt_d = sat_cnt_s;
                    mask_d    = mask_q | neq_s;
                    if ((|neq_s) && (mis_cnt_q == {CNT_W{1'b0}})) begin
                        fx_d = Pixel_X;
                        fy_d = Pixel_Y;
                    end else begin
                        fx_d = fx_q;
                        fy_d = fy_q;
                    end
                end else begin
                    mis_cnt_d = mis_cnt_q;
                end
                if (check_s && !Exp_valid) begin
                    underflow_d = 1'b1;
                end else begin
                    underflow_d = underflow_q;
                end
                // Halt takes priority; a frame end in the same cycle is dropped.
                if (mis_cnt_d > MAX_CNT) begin
                    state_d = S_HALT;
                end else if (vsync_fall_s) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    if (frame_cnt_d == NF_CNT) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT_FRAME;
                    end
                end else begin
                    state_d = S_CHECK;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_WAIT_FRAME) || (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
        halt_d = (state_d == S_HALT);
    end

    // State and output registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            vsync_q     <= 1'b0;
            mis_cnt_q   <= {CNT_W{1'b0}};
            mask_q      <= {CHANNELS{1'b0}};
            fx_q        <= 10'd0;
            fy_q        <= 10'd0;
            underflow_q <= 1'b0;
            frame_cnt_q <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            halt_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vsync_q     <= vsync_d;
            mis_cnt_q   <= mis_cnt_d;
            mask_q      <= mask_d;
            fx_q        <= fx_d;
            fy_q        <= fy_d;
            underflow_q <= underflow_d;
            frame_cnt_q <= frame_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            halt_q      <= halt_d;
        end
    end

    assign Mismatch_count = mis_cnt_q;
    assign Chan_err_mask  = mask_q;
    assign First_err_X    = fx_q;
    assign First_err_Y    = fy_q;
    assign Exp_underflow  = underflow_q;
    assign Frame_count    = frame_cnt_q;
    assign Busy           = busy_q;
    assign Done           = done_q;
    assign Halt           = halt_q;

`ifdef VGA_CHK_CRC_EN
    logic crc_clr_s;
    logic crc_init_s;

    assign crc_clr_s  = Start && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_HALT));
    assign crc_init_s = (state_q == S_WAIT_FRAME) && vsync_rise_s;

    vga_chk_crc16 #(
        .W(PIX_W)
    ) u_crc (
        .clk  (Clock),
        .rst  (Reset),
        .clr  (crc_clr_s),
        .init (crc_init_s),
        .en   (check_s),
        .data (Pixel_data),
        .crc  (Frame_crc)
    );
`else
    assign Frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_stream_checker.sv
// Randomised self-checking bench for vga_stream_checker with a behavioural
// reference model; the frame CRC is checked only when VGA_CHK_CRC_EN is defined.
module tb_vga_stream_checker;

    localparam int NF   = 2;
    localparam int MAXM = 10;

    logic        clk = 1'b0;
    logic        rst, start, vs, pv, ev;
    logic [9:0]  px, py;
    logic [23:0] pd, ed;

    logic        Exp_ready;
    logic [15:0] Mismatch_count;
    logic [2:0]  Chan_err_mask;
    logic [9:0]  First_err_X, First_err_Y;
    logic        Exp_underflow;
    logic [7:0]  Frame_count;
    logic        Busy, Done, Halt;
    logic [15:0] Frame_crc;

    always #5 clk = ~clk;

    vga_stream_checker #(.NUM_FRAMES(NF)) dut (
        .Clock(clk), .Reset(rst), .Start(start), .VGA_vsync(vs),
        .Pixel_valid(pv), .Pixel_X(px), .Pixel_Y(py), .Pixel_data(pd),
        .Exp_valid(ev), .Exp_data(ed), .Exp_ready(Exp_ready),
        .Mismatch_count(Mismatch_count), .Chan_err_mask(Chan_err_mask),
        .First_err_X(First_err_X), .First_err_Y(First_err_Y),
        .Exp_underflow(Exp_underflow), .Frame_count(Frame_count),
        .Busy(Busy), .Done(Done), .Halt(Halt), .Frame_crc(Frame_crc)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit in_win(input int x, input int y);
        return (x >= 160) && (x < 480) && (y >= 120) && (y < 360);
    endfunction

    function automatic logic [15:0] crc_bits(input logic [15:0] c, input logic [23:0] w, input int nb);
        logic fb;
        for (int i = nb - 1; i >= 0; i--) begin
            fb = c[15] ^ w[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    // Reference model: what the checker has observed so far.
    typedef enum {M_IDLE, M_WAIT, M_CHECK, M_DONE, M_HALT} ph_t;
    ph_t         ph = M_IDLE;
    int          m_cnt, m_fx, m_fy, m_frames;
    bit [2:0]    m_mask;
    bit          m_uf, m_vprev;
    logic [15:0] m_crc;

    task automatic m_clear();
        m_cnt = 0; m_fx = 0; m_fy = 0; m_frames = 0; m_mask = 3'b000; m_uf = 1'b0; m_crc = 16'h0000;
    endtask

    always @(posedge clk) begin
        int n;
        if (rst) begin
            m_clear();
            ph = M_IDLE;
            m_vprev = 1'b0;
        end else begin
            case (ph)
                M_IDLE, M_DONE, M_HALT: if (start) begin m_clear(); ph = M_WAIT; end
                M_WAIT: if (!m_vprev && vs) begin ph = M_CHECK; m_crc = 16'hFFFF; end
                M_CHECK: begin
                    if (pv && in_win(int'(px), int'(py))) begin
                        m_crc = crc_bits(m_crc, pd, 24);
                        if (ev) begin
                            n = 0;
                            for (int ch = 0; ch < 3; ch++) begin
                                if (pd[(2-ch)*8 +: 8] != ed[(2-ch)*8 +: 8]) begin
                                    n++;
                                    m_mask[ch] = 1'b1;
                                end
                            end
                            if (n > 0 && m_cnt == 0) begin m_fx = int'(px); m_fy = int'(py); end
                            m_cnt = (m_cnt + n > 65535) ? 65535 : m_cnt + n;
                        end else begin
                            m_uf = 1'b1;
                        end
                    end
                    if (m_cnt > MAXM) ph = M_HALT;
                    else if (m_vprev && !vs) begin
                        m_frames++;
                        ph = (m_frames == NF) ? M_DONE : M_WAIT;
                    end
                end
                default: ph = M_IDLE;
            endcase
            m_vprev = vs;
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        logic [15:0] exp_crc;
        if (chk_en) begin
`ifdef VGA_CHK_CRC_EN
            exp_crc = m_crc;
`else
            exp_crc = 16'h0000;
`endif
            cmp("Exp_ready", 32'(Exp_ready), 32'((ph == M_CHECK) && pv && ev && in_win(int'(px), int'(py))));
            cmp("Mismatch_count", 32'(Mismatch_count), 32'(m_cnt));
            cmp("Chan_err_mask", 32'(Chan_err_mask), 32'(m_mask));
            cmp("First_err_X", 32'(First_err_X), 32'(m_fx));
            cmp("First_err_Y", 32'(First_err_Y), 32'(m_fy));
            cmp("Exp_underflow", 32'(Exp_underflow), 32'(m_uf));
            cmp("Frame_count", 32'(Frame_count), 32'(m_frames));
            cmp("Busy", 32'(Busy), 32'((ph == M_WAIT) || (ph == M_CHECK)));
            cmp("Done", 32'(Done), 32'(ph == M_DONE));
            cmp("Halt", 32'(Halt), 32'(ph == M_HALT));
            cmp("Frame_crc", 32'(Frame_crc), 32'(exp_crc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; vs = 1'b1; pv = 1'b0; ev = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic arm();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic begin_frame();
        vs = 1'b0; tick(); tick(); vs = 1'b1; tick();
    endtask

    task automatic pix(input int x, input int y, input logic [23:0] d, input logic [23:0] e, input bit v);
        px = 10'(x); py = 10'(y); pd = d; ed = e; ev = v; pv = 1'b1;
        tick();
        pv = 1'b0; ev = 1'b0;
        tick();
    endtask

    task automatic probe_ready(input string nm, input int x, input int y, input bit v, input bit exp);
        px = 10'(x); py = 10'(y); pd = 24'h123456; ed = 24'h123456; ev = v; pv = 1'b1;
        #1;
        cmp(nm, 32'(Exp_ready), 32'(exp));
        tick();
        pv = 1'b0; ev = 1'b0;
        tick();
    endtask

    task automatic good_pixels(input int n);
        logic [23:0] d;
        for (int i = 0; i < n; i++) begin
            d = 24'($urandom);
            pix($urandom_range(140, 500), $urandom_range(100, 380), d, d, 1'b1);
        end
    endtask

    initial begin
        logic [15:0] pin;
        logic [23:0] d, e;
        rst = 1'b1; start = 1'b0; vs = 1'b1; pv = 1'b0; ev = 1'b0;
        px = 10'd0; py = 10'd0; pd = 24'd0; ed = 24'd0;

        // Pin the bench CRC routine to the CRC-16/CCITT-FALSE check value.
        pin = 16'hFFFF;
        for (int i = 1; i <= 9; i++) pin = crc_bits(pin, 24'(8'h30 + i), 8);
        cmp("crc_model_pin", 32'(pin), 32'h29B1);

        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        cmp("reset_count", 32'(Mismatch_count), 32'd0);
        cmp("reset_busy", 32'(Busy), 32'd0);

        // Two clean frames.
        arm();
        cmp("armed_busy", 32'(Busy), 32'd1);
        begin_frame(); good_pixels(30);
        vs = 1'b0; tick();
        cmp("clean_f1_count", 32'(Frame_count), 32'd1);
        cmp("clean_f1_done", 32'(Done), 32'd0);
        tick();
        begin_frame(); good_pixels(30);
        vs = 1'b0; tick();
        cmp("clean_done", 32'(Done), 32'd1);
        cmp("clean_frames", 32'(Frame_count), 32'd2);
        cmp("clean_mask", 32'(Chan_err_mask), 32'd0);
        tick();

        // First error latch, mask, underflow and window boundaries.
        do_reset(); arm(); begin_frame();
        pix(200, 130, 24'h104120, 24'h104020, 1'b1);
        cmp("green_count", 32'(Mismatch_count), 32'd1);
        cmp("green_mask", 32'(Chan_err_mask), 32'b010);
        cmp("first_x", 32'(First_err_X), 32'd200);
        cmp("first_y", 32'(First_err_Y), 32'd130);
        pix(300, 200, 24'hAA0000, 24'hAB0000, 1'b1);
        cmp("red_count", 32'(Mismatch_count), 32'd2);
        cmp("red_mask", 32'(Chan_err_mask), 32'b011);
        cmp("first_x_kept", 32'(First_err_X), 32'd200);
        probe_ready("ready_underflow", 160, 120, 1'b0, 1'b0);
        cmp("underflow", 32'(Exp_underflow), 32'd1);
        cmp("underflow_count", 32'(Mismatch_count), 32'd2);
        probe_ready("ready_outside", 100, 50, 1'b1, 1'b0);
        probe_ready("ready_corner", 479, 359, 1'b1, 1'b1);
        probe_ready("ready_right", 480, 200, 1'b1, 1'b0);
        probe_ready("ready_bottom", 200, 360, 1'b1, 1'b0);
        probe_ready("ready_left", 159, 200, 1'b1, 1'b0);
        vs = 1'b0; tick(); tick();

        // Halt after 4 all-channel failures (12 > 10).
        do_reset(); arm(); begin_frame();
        for (int i = 0; i < 3; i++) pix(170 + i, 125, 24'h000000, 24'hFFFFFF, 1'b1);
        cmp("pre_halt_count", 32'(Mismatch_count), 32'd9);
        cmp("pre_halt", 32'(Halt), 32'd0);
        pix(173, 125, 24'h000000, 24'hFFFFFF, 1'b1);
        cmp("halt_count", 32'(Mismatch_count), 32'd12);
        cmp("halt", 32'(Halt), 32'd1);
        cmp("halt_not_done", 32'(Done), 32'd0);
        vs = 1'b0; tick(); tick();
        cmp("halt_frozen_frames", 32'(Frame_count), 32'd0);

        // Reset in the middle of the second frame, then two full frames.
        do_reset(); arm(); begin_frame();
        pix(250, 250, 24'h010203, 24'h010200, 1'b1); good_pixels(10);
        vs = 1'b0; tick(); tick();
        begin_frame(); good_pixels(5);
        rst = 1'b1; tick(); rst = 1'b0;
        cmp("midreset_count", 32'(Mismatch_count), 32'd0);
        cmp("midreset_frames", 32'(Frame_count), 32'd0);
        cmp("midreset_busy", 32'(Busy), 32'd0);
        tick();
        arm();
        begin_frame(); good_pixels(15); vs = 1'b0; tick(); tick();
        begin_frame(); good_pixels(15); vs = 1'b0; tick();
        cmp("rearm_frames", 32'(Frame_count), 32'd2);
        cmp("rearm_done", 32'(Done), 32'd1);
        tick();

        // Single zero pixel signature.
        do_reset(); arm(); begin_frame();
        pix(250, 200, 24'h000000, 24'h000000, 1'b1);
`ifdef VGA_CHK_CRC_EN
        cmp("crc_zero_pixel", 32'(Frame_crc), 32'(crc_bits(16'hFFFF, 24'h000000, 24)));
`else
        cmp("crc_tied_off", 32'(Frame_crc), 32'd0);
`endif
        vs = 1'b0; tick(); tick();

        // Randomised frames; the compare process checks every cycle.
        for (int r = 0; r < 6; r++) begin
            do_reset(); arm();
            for (int f = 0; f < 3; f++) begin
                begin_frame();
                for (int i = 0; i < $urandom_range(20, 60); i++) begin
                    if ($urandom_range(0, 9) < 6) begin
                        px = 10'($urandom_range(150, 490)); py = 10'($urandom_range(110, 370));
                    end else begin
                        px = 10'($urandom_range(0, 639)); py = 10'($urandom_range(0, 479));
                    end
                    d = 24'($urandom);
                    e = d;
                    for (int ch = 0; ch < 3; ch++)
                        if ($urandom_range(0, 99) < 3) e[ch*8 +: 8] = e[ch*8 +: 8] ^ 8'(1 << $urandom_range(0, 7));
                    pd = d; ed = e;
                    pv = ($urandom_range(0, 1) == 1);
                    ev = ($urandom_range(0, 9) != 0);
                    start = ($urandom_range(0, 49) == 0);
                    tick();
                end
                pv = 1'b0; ev = 1'b0; start = 1'b0;
                vs = 1'b0; tick(); tick();
            end
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
